// File: rtl/elevator_pkg.sv
// Shared constants for the elevator scheduler: state encoding, default widths/duty,
// and floor-index to floor-number conversion.
package elevator_pkg;

  localparam int          DEF_FLOOR_W  = 3;
  localparam int          DEF_DUTY_W   = 20;
  localparam logic [19:0] DEF_DUTY_RUN = 20'd600000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MOVE_UP   = 3'd1;
  localparam logic [2:0] ST_MOVE_DOWN = 3'd2;
  localparam logic [2:0] ST_DOOR      = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  // Pending/hall bit i corresponds to floor number i+1.
  function automatic int unsigned idx2floor(input int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/elevator_request_bank.sv
// Pending-call register with set/clear arbitration, plus above/below masks and the
// nearest pending call on each side of the car's current floor index.
module elevator_request_bank
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NUM_FLOORS-1:0] i_set,
  input  logic [NUM_FLOORS-1:0] i_clr,
  input  logic [IDX_W-1:0]      i_cur_idx,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic [NUM_FLOORS-1:0] o_above,
  output logic [NUM_FLOORS-1:0] o_below,
  output logic [IDX_W-1:0]      o_near_above,
  output logic [IDX_W-1:0]      o_near_below
);

  logic [NUM_FLOORS-1:0] r_pending;

  // Clear wins so a call landing on the stop edge is absorbed.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_pending <= '0;
    else            r_pending <= (r_pending | i_set) & ~i_clr;
  end

  assign o_pending = r_pending;

  always_comb begin
    o_above = '0;
    o_below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (IDX_W'(i) > i_cur_idx) o_above[i] = r_pending[i];
      if (IDX_W'(i) < i_cur_idx) o_below[i] = r_pending[i];
    end
  end

  // Lowest set bit above and highest set bit below; default to the car's own floor.
  always_comb begin
    o_near_above = i_cur_idx;
    o_near_below = i_cur_idx;
    for (int i = NUM_FLOORS-1; i >= 0; i--)
      if (o_above[i]) o_near_above = IDX_W'(i);
    for (int i = 0; i < NUM_FLOORS; i++)
      if (o_below[i]) o_near_below = IDX_W'(i);
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-style elevator car sequencer: call latching, floor tracking, motor duty/direction,
// door dwell. Optional stall watchdog enabled by defining ELEV_STALL_TIMEOUT_EN.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int                NUM_FLOORS     = 4,
  parameter int                FLOOR_W        = DEF_FLOOR_W,
  parameter int                DUTY_W         = DEF_DUTY_W,
  parameter logic [DUTY_W-1:0] DUTY_RUN       = DUTY_W'(DEF_DUTY_RUN),
  parameter int unsigned       DWELL_CYCLES   = 200000000,
  parameter int unsigned       TIMEOUT_CYCLES = 500000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NUM_FLOORS-1:0] i_req_pulse,
  input  logic [NUM_FLOORS-1:0] i_floor_hit,
  output logic [DUTY_W-1:0]     o_motor_duty,
  output logic                  o_motor_dir_up,
  output logic                  o_door_open,
  output logic [FLOOR_W-1:0]    o_current_floor,
  output logic [FLOOR_W-1:0]    o_target_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_fault
);

  localparam int          IDX_W   = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [2:0]            r_state;
  logic [IDX_W-1:0]      r_cur_idx;
  logic [FLOOR_W-1:0]    r_cur_floor;
  logic [FLOOR_W-1:0]    r_target;
  logic [DUTY_W-1:0]     r_duty;
  logic                  r_dir_up;
  logic                  r_door;
  logic [CNT_W-1:0]      r_dwell;

  logic                  w_hit_any;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_moving;
  logic                  w_parked;
  logic                  w_stop;
  logic                  w_req_here;
  logic                  w_go_up;
  logic                  w_any_above;
  logic                  w_any_below;
  logic                  w_stall_expire;
  logic [NUM_FLOORS-1:0] w_here;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [NUM_FLOORS-1:0] w_pending;
  logic [NUM_FLOORS-1:0] w_above;
  logic [NUM_FLOORS-1:0] w_below;
  logic [IDX_W-1:0]      w_near_above;
  logic [IDX_W-1:0]      w_near_below;
  logic [FLOOR_W-1:0]    w_above_floor;
  logic [FLOOR_W-1:0]    w_below_floor;
  logic [FLOOR_W-1:0]    w_start_tgt;

  elevator_request_bank #(
    .NUM_FLOORS (NUM_FLOORS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_set        (w_set),
    .i_clr        (w_clr),
    .i_cur_idx    (r_cur_idx),
    .o_pending    (w_pending),
    .o_above      (w_above),
    .o_below      (w_below),
    .o_near_above (w_near_above),
    .o_near_below (w_near_below)
  );

  // Several hall bits at once: the lowest floor wins.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NUM_FLOORS-1; i >= 0; i--)
      if (i_floor_hit[i]) w_hit_idx = IDX_W'(i);
  end

  assign w_hit_any   = |i_floor_hit;
  assign w_moving    = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
  assign w_parked    = (r_state == ST_IDLE) || (r_state == ST_DOOR);
  assign w_any_above = |w_above;
  assign w_any_below = |w_below;

  assign w_stop = w_moving && w_hit_any &&
                  (w_pending[w_hit_idx] ||
                   ((r_state == ST_MOVE_UP)   && (w_hit_idx == IDX_W'(NUM_FLOORS-1))) ||
                   ((r_state == ST_MOVE_DOWN) && (w_hit_idx == '0)));

  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_here[i] = (r_cur_idx == IDX_W'(i));
      w_clr[i]  = w_stop && (w_hit_idx == IDX_W'(i));
    end
  end

  // A call for the floor the car is parked at just (re)opens the door.
  assign w_req_here = w_parked && |(i_req_pulse & w_here);
  assign w_set      = i_req_pulse & ~(w_parked ? w_here : '0);

  assign w_go_up       = r_dir_up ? (w_any_above || !w_any_below) : (w_any_above && !w_any_below);
  assign w_above_floor = FLOOR_W'(idx2floor(32'(w_near_above)));
  assign w_below_floor = FLOOR_W'(idx2floor(32'(w_near_below)));
  assign w_start_tgt   = w_go_up ? w_above_floor : w_below_floor;

`ifdef ELEV_STALL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_stall;
  logic             r_fault;

  assign w_stall_expire = w_moving && !w_hit_any && (r_stall == STALL_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                 r_stall <= '0;
    else if (!w_moving || w_hit_any) r_stall <= '0;
    else if (r_stall != STALL_LAST) r_stall <= r_stall + CNT_W'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)          r_fault <= 1'b0;
    else if (w_stall_expire) r_fault <= 1'b1;
  end

  assign o_fault = r_fault;
`else
  assign w_stall_expire = 1'b0;
  assign o_fault        = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_cur_idx   <= '0;
      r_cur_floor <= FLOOR_W'(1);
      r_target    <= '0;
      r_duty      <= '0;
      r_dir_up    <= 1'b1;
      r_door      <= 1'b0;
      r_dwell     <= '0;
    end else begin
      if (w_hit_any) begin
        r_cur_idx   <= w_hit_idx;
        r_cur_floor <= FLOOR_W'(idx2floor(32'(w_hit_idx)));
      end
      case (r_state)
        ST_IDLE: begin
          if (w_req_here) begin
            r_state <= ST_DOOR;
            r_door  <= 1'b1;
            r_dwell <= '0;
          end else if (|w_pending) begin
            r_state  <= w_go_up ? ST_MOVE_UP : ST_MOVE_DOWN;
            r_dir_up <= w_go_up;
            r_duty   <= DUTY_RUN;
            r_target <= w_start_tgt;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (w_stop) begin
            r_state  <= ST_DOOR;
            r_duty   <= '0;
            r_door   <= 1'b1;
            r_dwell  <= '0;
            r_target <= '0;
          end else if (w_stall_expire) begin
            r_state  <= ST_FAULT;
            r_duty   <= '0;
            r_target <= '0;
          end else if (r_state == ST_MOVE_UP) begin
            if (w_any_above) r_target <= w_above_floor;
          end else begin
            if (w_any_below) r_target <= w_below_floor;
          end
        end
        ST_DOOR: begin
          if (w_req_here) begin
            r_dwell <= '0;
          end else if (r_dwell == DWELL_LAST) begin
            r_door <= 1'b0;
            if (w_any_above || w_any_below) begin
              r_state  <= w_go_up ? ST_MOVE_UP : ST_MOVE_DOWN;
              r_dir_up <= w_go_up;
              r_duty   <= DUTY_RUN;
              r_target <= w_start_tgt;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_dwell <= r_dwell + CNT_W'(1);
          end
        end
`ifdef ELEV_STALL_TIMEOUT_EN
        ST_FAULT: r_state <= ST_FAULT;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_motor_duty    = r_duty;
  assign o_motor_dir_up  = r_dir_up;
  assign o_door_open     = r_door;
  assign o_current_floor = r_cur_floor;
  assign o_target_floor  = r_target;
  assign o_pending       = w_pending;

endmodule
